// File: rtl/mmul_pkg.sv
// Shared definitions for the matrix-multiply command controller:
// opcodes, default geometry and the controller state type.
package mmul_pkg;

  localparam int N_DEF     = 10;
  localparam int IDX_W_DEF = 7;

  localparam logic [5:0] OP_INIT   = 6'd10;
  localparam logic [5:0] OP_FILLA  = 6'd11;
  localparam logic [5:0] OP_FILLB  = 6'd12;
  localparam logic [5:0] OP_RESULT = 6'd13;
  localparam logic [5:0] OP_MULT   = 6'd25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mmul_loop_cnt.sv
// Nested i/j/k iteration counter (k innermost) with last-iteration flags.
module mmul_loop_cnt #(
  parameter int N  = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] k,
  output logic          k_last,
  output logic          all_last
);

  localparam logic [CW-1:0] LIM  = CW'(N - 1);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] i_q, j_q, k_q;
  logic [CW-1:0] i_d, j_d, k_d;
  logic          i_last, j_last;

  assign i        = i_q;
  assign j        = j_q;
  assign k        = k_q;
  assign i_last   = (i_q == LIM);
  assign j_last   = (j_q == LIM);
  assign k_last   = (k_q == LIM);
  assign all_last = i_last & j_last & k_last;

  // Odometer-style advance: k rolls into j, j rolls into i.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = ZERO;
      j_d = ZERO;
      k_d = ZERO;
    end else if (step) begin
      if (k_last) begin
        k_d = ZERO;
        if (j_last) begin
          j_d = ZERO;
          i_d = i_last ? ZERO : i_q + ONE;
        end else begin
          j_d = j_q + ONE;
        end
      end else begin
        k_d = k_q + ONE;
      end
    end else begin
      k_d = k_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= ZERO;
      j_q <= ZERO;
      k_q <= ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/mmul_ctrl.sv
// Command controller for an N x N matrix multiplier: operand fill, MAC
// sequencing with result write-back, and single-element result readout.
module mmul_ctrl
  import mmul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_val,
  output logic             busy,
  input  logic [5:0]       cmd_opcode,
  input  logic [63:0]      cmd_config_data,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [63:0]      resp_data,
  output logic [63:0]      wr_data,
  output logic             a_wr_en,
  output logic [IDX_W-1:0] a_wr_idx,
  output logic             b_wr_en,
  output logic [IDX_W-1:0] b_wr_idx,
  output logic             clr_all,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [IDX_W-1:0] rd_a_idx,
  output logic [IDX_W-1:0] rd_b_idx,
  output logic             r_wr_en,
  output logic [IDX_W-1:0] r_wr_idx,
  output logic [IDX_W-1:0] r_rd_idx,
  input  logic [63:0]      r_rd_data
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  function automatic logic [IDX_W-1:0] flat_idx(input logic [CW-1:0] row,
                                                input logic [CW-1:0] col);
    return IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
  endfunction

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? ZERO_IDX : p + ONE_IDX;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] a_ptr_q, a_ptr_d;
  logic [IDX_W-1:0] b_ptr_q, b_ptr_d;
  logic [IDX_W-1:0] r_ptr_q, r_ptr_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic             is_result_q, is_result_d;
  logic             wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

  logic          cmd_acc;
  logic          loop_clr, loop_step;
  logic [CW-1:0] li, lj, lk;
  logic          k_last, all_last;

  mmul_loop_cnt #(.N(N), .CW(CW)) u_loop (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (loop_clr),
    .step     (loop_step),
    .i        (li),
    .j        (lj),
    .k        (lk),
    .k_last   (k_last),
    .all_last (all_last)
  );

  assign busy      = (state_q != ST_IDLE);
  assign cmd_acc   = cmd_val & ~busy;
  assign resp_val  = (state_q == ST_RESP);
  assign resp_data = resp_data_q;
  assign wr_data   = cmd_config_data;
  assign a_wr_idx  = a_ptr_q;
  assign b_wr_idx  = b_ptr_q;
  assign r_rd_idx  = r_ptr_q;
  assign rd_a_idx  = flat_idx(li, lk);
  assign rd_b_idx  = flat_idx(lk, lj);
  // Write-back lags the k==N-1 issue by one cycle so the last product is in.
  assign r_wr_en   = wr_pend_q;
  assign r_wr_idx  = wr_idx_q;

  // Command decode, MAC sequencing and response handshake.
  always_comb begin
    state_d     = state_q;
    a_ptr_d     = a_ptr_q;
    b_ptr_d     = b_ptr_q;
    r_ptr_d     = r_ptr_q;
    resp_data_d = resp_data_q;
    is_result_d = is_result_q;
    wr_pend_d   = 1'b0;
    wr_idx_d    = wr_idx_q;
    loop_clr    = 1'b0;
    loop_step   = 1'b0;
    clr_all     = 1'b0;
    a_wr_en     = 1'b0;
    b_wr_en     = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (cmd_opcode)
            OP_INIT: begin
              clr_all = 1'b1;
              a_ptr_d = ZERO_IDX;
              b_ptr_d = ZERO_IDX;
              r_ptr_d = ZERO_IDX;
            end
            OP_FILLA: begin
              a_wr_en = 1'b1;
              a_ptr_d = ptr_inc(a_ptr_q);
            end
            OP_FILLB: begin
              b_wr_en = 1'b1;
              b_ptr_d = ptr_inc(b_ptr_q);
            end
            OP_MULT: begin
              loop_clr    = 1'b1;
              is_result_d = 1'b0;
              state_d     = ST_MULT;
            end
            OP_RESULT: begin
              resp_data_d = r_rd_data;
              is_result_d = 1'b1;
              state_d     = ST_RESP;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        mac_en    = 1'b1;
        mac_clr   = (lk == {CW{1'b0}});
        loop_step = 1'b1;
        if (k_last) begin
          wr_pend_d = 1'b1;
          wr_idx_d  = flat_idx(li, lj);
        end else begin
          wr_pend_d = 1'b0;
        end
        if (all_last) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_MULT;
        end
      end
      ST_FLUSH: begin
        resp_data_d = 64'd0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_rdy) begin
          state_d = ST_IDLE;
          if (is_result_q) begin
            r_ptr_d = ptr_inc(r_ptr_q);
          end else begin
            r_ptr_d = r_ptr_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pointer registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_ptr_q     <= ZERO_IDX;
      b_ptr_q     <= ZERO_IDX;
      r_ptr_q     <= ZERO_IDX;
      resp_data_q <= 64'd0;
      is_result_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= ZERO_IDX;
    end else begin
      state_q     <= state_d;
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      r_ptr_q     <= r_ptr_d;
      resp_data_q <= resp_data_d;
      is_result_q <= is_result_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

endmodule

// File: tb/tb_mmul_ctrl.sv
// Directed bench for mmul_ctrl: table-driven single commands plus
// hand-written MULT, held-response and mid-operation reset sequences.
module tb_mmul_ctrl;
  import mmul_pkg::*;

  localparam int N     = 10;
  localparam int IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_val;
  logic             busy;
  logic [5:0]       cmd_opcode;
  logic [63:0]      cmd_config_data;
  logic             resp_val;
  logic             resp_rdy;
  logic [63:0]      resp_data;
  logic [63:0]      wr_data;
  logic             a_wr_en, b_wr_en, clr_all, mac_en, mac_clr, r_wr_en;
  logic [IDX_W-1:0] a_wr_idx, b_wr_idx, rd_a_idx, rd_b_idx, r_wr_idx, r_rd_idx;
  logic [63:0]      r_rd_data;

  mmul_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .busy(busy),
    .cmd_opcode(cmd_opcode), .cmd_config_data(cmd_config_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .wr_data(wr_data), .a_wr_en(a_wr_en), .a_wr_idx(a_wr_idx),
    .b_wr_en(b_wr_en), .b_wr_idx(b_wr_idx), .clr_all(clr_all),
    .mac_en(mac_en), .mac_clr(mac_clr), .rd_a_idx(rd_a_idx),
    .rd_b_idx(rd_b_idx), .r_wr_en(r_wr_en), .r_wr_idx(r_wr_idx),
    .r_rd_idx(r_rd_idx), .r_rd_data(r_rd_data)
  );

  always #5 clk = ~clk;

  // Storage and accumulator environment driven by the controller strobes.
  logic [63:0] ma [0:127];
  logic [63:0] mb [0:127];
  logic [63:0] mr [0:127];
  logic [63:0] acc;

  assign r_rd_data = mr[r_rd_idx];

  always @(posedge clk) begin
    if (clr_all) begin
      for (int e = 0; e < 128; e++) begin
        ma[e] <= 64'd0;
        mb[e] <= 64'd0;
        mr[e] <= 64'd0;
      end
    end
    if (a_wr_en) ma[a_wr_idx] <= wr_data;
    if (b_wr_en) mb[b_wr_idx] <= wr_data;
    if (mac_en) acc <= mac_clr ? ma[rd_a_idx] * mb[rd_b_idx]
                               : acc + ma[rd_a_idx] * mb[rd_b_idx];
    if (r_wr_en) mr[r_wr_idx] <= acc;
  end

  typedef struct {
    logic [5:0]  op;
    logic [63:0] data;
    logic        e_clr;
    logic        e_a;
    logic        e_b;
    logic [6:0]  e_idx;
    logic [6:0]  e_ridx;
    logic        e_resp;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("r_rd_idx", {57'd0, r_rd_idx}, {57'd0, v.e_ridx});
    cmd_val = 1'b1; cmd_opcode = v.op; cmd_config_data = v.data; resp_rdy = 1'b1;
    #1;
    chk("clr_all", {63'd0, clr_all}, {63'd0, v.e_clr});
    chk("a_wr_en", {63'd0, a_wr_en}, {63'd0, v.e_a});
    chk("b_wr_en", {63'd0, b_wr_en}, {63'd0, v.e_b});
    chk("wr_data", wr_data, v.data);
    if (v.e_a) chk("a_wr_idx", {57'd0, a_wr_idx}, {57'd0, v.e_idx});
    if (v.e_b) chk("b_wr_idx", {57'd0, b_wr_idx}, {57'd0, v.e_idx});
    tick();
    cmd_val = 1'b0;
    #1;
    chk("resp_val", {63'd0, resp_val}, {63'd0, v.e_resp});
    if (v.e_resp) begin
      chk("resp_data", resp_data, v.e_rdata);
      tick();
    end
  endtask

  int cnt, m, wr_cnt, seen;
  logic exp_mac, exp_w;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_val = 1'b0; cmd_opcode = 6'd0; cmd_config_data = 64'd0; resp_rdy = 1'b0;
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_resp_val", {63'd0, resp_val}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_strobes", {58'd0, mac_en, mac_clr, r_wr_en, a_wr_en, b_wr_en, clr_all}, 64'd0);
    chk("rst_r_rd_idx", {57'd0, r_rd_idx}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // INIT, A = identity, B = 1..100
    tbl.push_back('{OP_INIT, 64'd0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 64'd0});
    for (int n = 0; n < 100; n++)
      tbl.push_back('{OP_FILLA, (n % 11 == 0) ? 64'd1 : 64'd0, 1'b0, 1'b1, 1'b0,
                      7'(n), 7'd0, 1'b0, 64'd0});
    for (int n = 0; n < 100; n++)
      tbl.push_back('{OP_FILLB, 64'(n + 1), 1'b0, 1'b0, 1'b1, 7'(n), 7'd0, 1'b0, 64'd0});
    foreach (tbl[t]) apply(tbl[t]);

    // MULT with FILLA held on cmd_val throughout
    chk("mult_busy0", {63'd0, busy}, 64'd0);
    cmd_val = 1'b1; cmd_opcode = OP_MULT; cmd_config_data = 64'd0; resp_rdy = 1'b1;
    tick();
    cmd_opcode = OP_FILLA; cmd_config_data = 64'd1;
    cnt = 1; wr_cnt = 0;
    while (cnt <= 1100) begin
      #1;
      m = cnt - 1;
      exp_mac = (cnt <= 1000);
      chk("mac_en", {63'd0, mac_en}, {63'd0, exp_mac});
      chk("mac_clr", {63'd0, mac_clr}, {63'd0, exp_mac && (m % 10 == 0)});
      if (exp_mac) begin
        chk("rd_a_idx", {57'd0, rd_a_idx}, 64'((m / 100) * 10 + m % 10));
        chk("rd_b_idx", {57'd0, rd_b_idx}, 64'((m % 10) * 10 + (m / 10) % 10));
      end
      exp_w = (cnt >= 11) && (cnt <= 1001) && ((cnt - 1) % 10 == 0);
      chk("r_wr_en", {63'd0, r_wr_en}, {63'd0, exp_w});
      if (exp_w) chk("r_wr_idx", {57'd0, r_wr_idx}, 64'((cnt - 11) / 10));
      if (r_wr_en) wr_cnt++;
      chk("held_a_wr_en", {63'd0, a_wr_en}, 64'd0);
      if (resp_val) break;
      chk("mult_busy", {63'd0, busy}, 64'd1);
      tick();
      cnt++;
    end
    chk("mult_latency", 64'(cnt), 64'd1002);
    chk("mult_resp_data", resp_data, 64'd0);
    chk("r_wr_pulses", 64'(wr_cnt), 64'd100);
    tick();
    chk("held_fill_accept", {63'd0, a_wr_en}, 64'd1);
    chk("held_fill_idx", {57'd0, a_wr_idx}, 64'd0);
    cmd_val = 1'b0;
    tick();

    // 101 RESULT reads, last one wraps to R[0]
    tbl.delete();
    for (int n = 0; n < 101; n++)
      tbl.push_back('{OP_RESULT, 64'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'(n % 100), 1'b1,
                      64'((n % 100) + 1)});
    foreach (tbl[t]) apply(tbl[t]);

    // RESULT held with resp_rdy low
    chk("hold_ptr0", {57'd0, r_rd_idx}, 64'd1);
    cmd_val = 1'b1; cmd_opcode = OP_RESULT; resp_rdy = 1'b0;
    tick();
    cmd_val = 1'b0;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("hold_resp_val", {63'd0, resp_val}, 64'd1);
      chk("hold_resp_data", resp_data, 64'd2);
      chk("hold_ptr", {57'd0, r_rd_idx}, 64'd1);
      chk("hold_busy", {63'd0, busy}, 64'd1);
      if (h < 4) tick();
    end
    resp_rdy = 1'b1;
    tick();
    #1;
    chk("hold_ptr_adv", {57'd0, r_rd_idx}, 64'd2);
    chk("hold_idle", {63'd0, busy}, 64'd0);
    apply('{OP_RESULT, 64'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 64'd3});

    // Reset at MULT cycle 500
    cmd_val = 1'b1; cmd_opcode = OP_MULT;
    tick();
    cmd_val = 1'b0;
    repeat (499) tick();
    chk("pre_rst_mac", {63'd0, mac_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_strobes", {58'd0, mac_en, mac_clr, r_wr_en, a_wr_en, b_wr_en, clr_all}, 64'd0);
    chk("arst_resp_val", {63'd0, resp_val}, 64'd0);
    chk("arst_r_rd_idx", {57'd0, r_rd_idx}, 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (resp_val || r_wr_en || mac_en) seen++;
    end
    chk("arst_no_activity", 64'(seen), 64'd0);
    apply('{OP_RESULT, 64'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 64'd1});

    // Unknown opcode ignored, then FILLA at index 0
    apply('{6'd7, 64'd9, 1'b0, 1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 64'd0});
    apply('{OP_FILLA, 64'h5, 1'b0, 1'b1, 1'b0, 7'd0, 7'd1, 1'b0, 64'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmul_ctrl.md
MMUL_CTRL -- requirements
Module: mmul_ctrl

Interface
REQ-001 SHALL have parameter N, default 10, meaning matrix dimension (N x N operands and result).
REQ-002 SHALL have parameter IDX_W, default 7, meaning flat element-index width; must satisfy 2^IDX_W >= N*N.
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_val  in  1  command valid.
- busy  out  1  command not accepted (acts as inverted cmd_rdy).
- cmd_opcode  in  6  command code.
- cmd_config_data  in  64  command payload.
- resp_val  out  1  response valid.
- resp_rdy  in  1  core accepts response.
- resp_data  out  64  response payload.
- wr_data  out  64  operand write data (equals cmd_config_data).
- a_wr_en  out  1  write matrix A element.
- a_wr_idx  out  IDX_W  flat A write index.
- b_wr_en  out  1  write matrix B element.
- b_wr_idx  out  IDX_W  flat B write index.
- clr_all  out  1  zero all A/B/R storage.
- mac_en  out  1  accumulate one product.
- mac_clr  out  1  restart accumulator with this product.
- rd_a_idx  out  IDX_W  A read index (i*N+k).
- rd_b_idx  out  IDX_W  B read index (k*N+j).
- r_wr_en  out  1  write accumulator to R.
- r_wr_idx  out  IDX_W  R write index (i*N+j).
- r_rd_idx  out  IDX_W  R read index.
- r_rd_data  in  64  R element at r_rd_idx, combinational.

Function
REQ-004 A command SHALL be accepted in any cycle with cmd_val=1 and busy=0; no command is accepted while busy=1.
REQ-005 Opcodes SHALL be: INIT=10, FILLA=11, FILLB=12, RESULT=13, MULT=25; any other opcode SHALL be accepted and ignored, producing no response.
REQ-006 States SHALL be IDLE, MULT, FLUSH, RESP; busy SHALL be 0 in IDLE only.
REQ-007 INIT SHALL pulse clr_all for one cycle, combinationally in the acceptance cycle, and reset the A, B and R-read pointers to 0; it produces no response.
REQ-008 FILLA SHALL assert a_wr_en combinationally in the acceptance cycle, with a_wr_idx equal to the A pointer; the pointer then increments and wraps from N*N-1 to 0; it produces no response.
REQ-009 FILLB SHALL behave identically to FILLA, using b_wr_en, b_wr_idx and the B pointer.
REQ-010 MULT SHALL enter MULT the next cycle and issue one product per cycle for N^3 cycles, with k innermost, then j, then i.
REQ-011 In each MULT cycle, mac_en=1 and mac_clr=(k==0).
REQ-012 The cycle after each k==N-1 issue SHALL assert r_wr_en with r_wr_idx=i*N+j; this overlaps the next element's first product.
REQ-013 After the last issue, the controller SHALL spend one FLUSH cycle for the final r_wr_en, then enter RESP with resp_val=1 and resp_data=64'd0.
REQ-014 The first resp_val for MULT SHALL occur N^3+2 cycles after acceptance (1002 for N=10).
REQ-015 RESULT SHALL drive r_rd_idx equal to the R-read pointer, register r_rd_data into resp_data at acceptance, and assert resp_val in RESP the next cycle.
REQ-016 In RESP, resp_val and resp_data SHALL be held stable until resp_rdy=1; on that handshake the controller returns to IDLE and may accept a new command the following cycle.
REQ-017 The R-read pointer SHALL increment on each RESULT handshake and wrap from N*N-1 to 0.
REQ-018 When not active, mac_en, mac_clr, r_wr_en, a_wr_en, b_wr_en and clr_all SHALL be 0; index outputs are don't-care except r_rd_idx, which always equals the R-read pointer.
REQ-019 Fill and RESULT pointers SHALL be unaffected by MULT.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state IDLE, all pointers and loop counters to 0, busy=0, resp_val=0, resp_data=0, and all strobes to 0.
REQ-021 A reset asserted mid-MULT or mid-RESP SHALL abort the operation with no response and no further r_wr_en.

Structure
REQ-022 A shared package mmul_pkg SHALL hold the opcode constants, the default N and IDX_W, and the state enum type.
REQ-023 The nested i/j/k counter with last-iteration flags SHALL be a sub-module named mmul_loop_cnt.

Verification
REQ-024 With N=10: INIT, fill A with the identity, fill B with 1..100, MULT -> resp_val after exactly 1002 cycles with data 0; 100 r_wr_en pulses with idx 0..99.
REQ-025 After REQ-024, 100 RESULT commands with resp_rdy=1 -> resp_data sequence 1..100; a 101st RESULT -> 1 (pointer wrap).
REQ-026 cmd_val held high with FILLA during MULT -> busy=1, no a_wr_en until the MULT response handshake completes.
REQ-027 RESULT issued with resp_rdy=0 for 5 cycles -> resp_val and resp_data held constant for 5 cycles; the pointer advances only after resp_rdy=1.
REQ-028 rst_n pulsed low at MULT cycle 500 -> busy=0 and all strobes 0 immediately; no resp_val; a following RESULT returns R[0].
REQ-029 Opcode 7 followed by FILLA of 64'h5 -> no response for opcode 7; a_wr_en with idx 0 and wr_data 5.
